spi_cfg_master: RTL and testbench
=================================

# spi_cfg_master

SPI controller that configures the on-chip SPI register peripheral (output-enable, PWM-enable and PWM duty-cycle registers) from a parallel write-command interface. Commands are buffered in a small FIFO and serialized as 16-bit SPI mode-0 write frames. Each frame is one write bit, a 7-bit address and 8-bit data, sent MSB first. The block sits on the host side of the serial link and drives `sCLK`, `nCS` and `COPI`, with frame pacing set so the peripheral's synchronizers resolve every edge.

## Interface
- `CLK_DIV`, 4: `sCLK` half-period in `clk` cycles; legal range ≥2.
- `FIFO_DEPTH`, 4: command FIFO entries; must be a power of 2.
- `GAP_CYCLES`, 8: minimum number of `nCS`-high cycles between frames; legal range ≥4.
- `clk` in 1: fast system clock. There is one clock in the block.
- `rst_n` in 1: reset, synchronous, active-low.
- `cmd_valid` in 1: write command offered.
- `cmd_ready` out 1: FIFO can accept a command.
- `cmd_addr` in 7: target register address.
- `cmd_data` in 8: register data.
- `busy` out 1: a frame is in flight or the FIFO is non-empty.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of FIFO entries occupied.
- `frames_done` out 8: count of completed frames; wraps at 256.
- `sCLK` out 1: SPI clock, idle low.
- `nCS` out 1: chip select, active low.
- `COPI` out 1: serial data to the peripheral.

## Operation
- Frame format: `{1'b1, cmd_addr[6:0], cmd_data[7:0]}`, shifted MSB first. Addresses ≥0x05 are forwarded unchanged; no filtering is applied.
- FIFO behaviour:
  - A push occurs when `cmd_valid && cmd_ready`.
  - `cmd_ready = rst_n && (fifo_count != FIFO_DEPTH)`.
  - A pop occurs only in IDLE, when the registered count is non-zero.
- Simultaneous push and pop: count is unchanged.
- Push into an empty FIFO: the entry is popped no earlier than the following cycle.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
  - IDLE: if the FIFO is non-empty, pop, load the 16-bit shift register and go to SETUP. Otherwise stay.
  - SETUP: `nCS`=0, `sCLK`=0, `COPI`=frame bit 15. Hold for `CLK_DIV` cycles, then go to SHIFT.
  - SHIFT: 32 half-periods of `CLK_DIV` cycles each, alternating `sCLK` high then low.
    - On each falling edge except the last, shift `COPI` to the next bit.
    - After the 32nd half-period, go to HOLD.
  - HOLD: `nCS`=0, `sCLK`=0 for `CLK_DIV` cycles. Then go to GAP and increment `frames_done`.
  - GAP: `nCS`=1 for `GAP_CYCLES` cycles, then go to IDLE.
- Half-period and gap timing use one shared down-counter. The bit index is a 5-bit half-period counter.
- Reset (synchronous; also applies mid-frame):
  - Values after the next edge: state=IDLE, `nCS`=1, `sCLK`=0, `COPI`=0, `fifo_count`=0, `frames_done`=0, `busy`=0.
  - The FIFO is flushed.
  - A truncated frame leaves the peripheral registers untouched.

## Timing
- All serial outputs are driven directly from flops; no combinational path exists to the pins.
- Pop to `nCS` falling: 1 cycle.
- `nCS` low duration: 34·`CLK_DIV` cycles (136 at default).
- Frame period with a non-empty FIFO: 34·`CLK_DIV` + `GAP_CYCLES` + 1 cycles (145 at default). The +1 is the IDLE pop cycle.
- Edge alignment:
  - `COPI` changes only on `sCLK` falling edges or at SETUP entry.
  - `COPI` is stable for ≥`CLK_DIV` cycles on each side of every rising edge.
- `frames_done` increments in the cycle HOLD exits.
- `busy` is asserted in the cycle after the first push and deasserts in the cycle after GAP exits with an empty FIFO.
- `cmd_ready` is combinational from the registered count only; it does not depend on `cmd_valid`.

## Structure
- Package `spi_cfg_pkg` contains:
  - Register address constants: `ADDR_EN_OUT_7_0`=0x00, `ADDR_EN_OUT_15_8`=0x01, `ADDR_EN_PWM_7_0`=0x02, `ADDR_EN_PWM_15_8`=0x03, `ADDR_PWM_DUTY`=0x04.
  - `SPI_RW_WRITE`=1.
  - `SPI_FRAME_BITS`=16.
  - The FSM state enum.
- Sub-module `cmd_fifo`: synchronous FIFO, 15-bit wide, `FIFO_DEPTH` entries, with pointers that wrap and a count output. It is instantiated once.
- The top level holds the FSM, the timing counter, the shift register and `frames_done`.

## Test plan
- Single write, `addr`=0x04, `data`=0x80, default parameters:
  - `COPI` sampled at `sCLK` rising edges reads 1_0000100_10000000.
  - `nCS` is low for exactly 136 cycles.
  - `frames_done`=1 and `busy`=0 after the gap.
- Loopback with the SPI peripheral: write 0xA5, 0x5A, 0xFF, 0x01, 0x40 to addresses 0x00–0x04.
  - Each peripheral output register matches its written value.
  - A write to 0x07 changes nothing.
- FIFO full: push 5 commands back-to-back.
  - `cmd_ready` drops after the 4th push and rises the cycle after the first pop.
  - The 5th command is accepted then, and all 5 frames are emitted in order.
  - Every gap is ≥8 cycles.
- Simultaneous push and pop: push exactly in the IDLE pop cycle with `fifo_count`=2. `fifo_count` stays at 2.
- Reset mid-frame: assert `rst_n`=0 for 1 cycle during bit 7 of the SHIFT state.
  - On the next edge: `nCS`=1, `sCLK`=0, `fifo_count`=0.
  - The peripheral registers keep their prior values.
- Counter wrap: run 257 frames. `frames_done` reads 0x01 and no frame is dropped.

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the SPI configuration master: peripheral register map,
// frame layout constants, FSM state type and the frame builder.
package spi_cfg_pkg;

    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    localparam logic       SPI_RW_WRITE     = 1'b1;
    localparam int         SPI_FRAME_BITS   = 16;
    localparam int         CMD_W            = SPI_FRAME_BITS - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_e;

    function automatic logic [SPI_FRAME_BITS-1:0] build_frame(input logic [CMD_W-1:0] cmd);
        return {SPI_RW_WRITE, cmd};
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO holding {addr, data} words; power-of-two depth so the
// pointers wrap naturally, plus an occupancy count.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [WIDTH-1:0]       wdata_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push_i && !pop_i)      count_d = count_q + 1'b1;
        else if (pop_i && !push_i) count_d = count_q - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count decide which entries are live.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/spi_cfg_master.sv
// Host-side SPI mode-0 write master: drains the command FIFO into 16-bit
// frames with paced sCLK and a guaranteed nCS-high gap between frames.
module spi_cfg_master
    import spi_cfg_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [6:0]                  cmd_addr,
    input  logic [7:0]                  cmd_data,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [7:0]                  frames_done,
    output logic                        sCLK,
    output logic                        nCS,
    output logic                        COPI
);

    localparam int CW      = $clog2(FIFO_DEPTH) + 1;
    localparam int TMR_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);

    localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);
    localparam logic [4:0]       LAST_HALF = 5'd31;
    localparam logic [4:0]       LAST_FALL = 5'd30;

    state_e                    state_q;
    logic [SPI_FRAME_BITS-1:0] shift_q;
    logic [TMR_W-1:0]          tmr_q;
    logic [4:0]                half_q;
    logic [7:0]                frames_q;
    logic                      ncs_q, sclk_q, copi_q;

    logic [CMD_W-1:0]          fifo_rdata;
    logic [CW-1:0]             count;
    logic                      push, pop;

    assign cmd_ready = rst_n && (count != CW'(FIFO_DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == ST_IDLE) && (count != '0);

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({cmd_addr, cmd_data}),
        .rdata_o (fifo_rdata),
        .count_o (count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shift_q  <= '0;
            tmr_q    <= '0;
            half_q   <= '0;
            frames_q <= '0;
            ncs_q    <= 1'b1;
            sclk_q   <= 1'b0;
            copi_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (pop) begin
                        shift_q <= build_frame(fifo_rdata);
                        copi_q  <= SPI_RW_WRITE;
                        ncs_q   <= 1'b0;
                        tmr_q   <= HALF_LOAD;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tmr_q != '0) begin
                        tmr_q <= tmr_q - 1'b1;
                    end else begin
                        sclk_q  <= 1'b1;
                        half_q  <= '0;
                        tmr_q   <= HALF_LOAD;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tmr_q != '0) begin
                        tmr_q <= tmr_q - 1'b1;
                    end else begin
                        tmr_q <= HALF_LOAD;
                        if (half_q == LAST_HALF) begin
                            sclk_q  <= 1'b0;
                            state_q <= ST_HOLD;
                        end else begin
                            half_q <= half_q + 1'b1;
                            sclk_q <= ~sclk_q;
                            // Advance data on falling edges; bit 0 stays put through the final fall.
                            if (sclk_q && half_q != LAST_FALL) begin
                                copi_q  <= shift_q[SPI_FRAME_BITS-2];
                                shift_q <= {shift_q[SPI_FRAME_BITS-2:0], 1'b0};
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (tmr_q != '0) begin
                        tmr_q <= tmr_q - 1'b1;
                    end else begin
                        ncs_q    <= 1'b1;
                        copi_q   <= 1'b0;
                        frames_q <= frames_q + 1'b1;
                        tmr_q    <= GAP_LOAD;
                        state_q  <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tmr_q != '0) tmr_q   <= tmr_q - 1'b1;
                    else             state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy        = (state_q != ST_IDLE) || (count != '0);
    assign fifo_count  = count;
    assign frames_done = frames_q;
    assign sCLK        = sclk_q;
    assign nCS         = ncs_q;
    assign COPI        = copi_q;

endmodule

// File: tb/tb_spi_cfg_master.sv
`timescale 1ns/1ps
// Bench for spi_cfg_master: a serial-side monitor decodes frames into a peripheral
// register model and a scoreboard of expected frames, with frame timing checks.
module tb_spi_cfg_master;
    import spi_cfg_pkg::*;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int GAP_CYCLES = 8;
    localparam int NCS_LOW    = 34 * CLK_DIV;
    localparam int PERIOD     = NCS_LOW + GAP_CYCLES + 1;
    localparam int NREGS      = 5;
    localparam int LIMIT      = 5000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_ready, busy, sCLK, nCS, COPI;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic [7:0] frames_done;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  exp_regs [NREGS];
    logic [7:0]  periph   [NREGS];

    // Serial monitor state
    int          cyc = 0, low_len = 0, high_len = 0, run_len = 0, half_bad = 0, bits = 0;
    int          rx_count = 0;
    int          fall_cyc[$];
    logic        prev_ncs = 1'b1, prev_sclk = 1'b0, gap_valid = 1'b0;
    logic [15:0] rx_sr = '0, last_frame = '0, mon_exp = '0;

    spi_cfg_master #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_data    (cmd_data),
        .busy        (busy),
        .fifo_count  (fifo_count),
        .frames_done (frames_done),
        .sCLK        (sCLK),
        .nCS         (nCS),
        .COPI        (COPI)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_push(input logic [6:0] a, input logic [7:0] d);
        exp_q.push_back({SPI_RW_WRITE, a, d});
        if (a < 7'(NREGS)) exp_regs[a[2:0]] = d;
    endfunction

    // Sample once per cycle, mid-cycle; a complete frame is 16 rising edges inside one nCS-low window.
    always @(negedge clk) begin
        cyc++;
        if (nCS === 1'b0) begin
            if (prev_ncs) begin
                if (gap_valid) check("gap_min", 32'(high_len >= GAP_CYCLES), 1);
                fall_cyc.push_back(cyc);
                low_len = 0; run_len = 1; half_bad = 0; bits = 0; rx_sr = '0;
            end else if (sCLK != prev_sclk) begin
                if (run_len != CLK_DIV) half_bad++;
                run_len = 1;
                if (sCLK) begin
                    rx_sr = {rx_sr[14:0], COPI};
                    bits++;
                end
            end else begin
                run_len++;
            end
            low_len++;
        end else begin
            if (!prev_ncs) begin
                gap_valid = (bits == 16);
                if (bits == 16) begin
                    check("ncs_low_len", low_len, NCS_LOW);
                    check("sclk_half_period", half_bad, 0);
                    check("frame_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        mon_exp = exp_q.pop_front();
                        check("frame_bits", rx_sr, mon_exp);
                    end
                    if (rx_sr[15] && rx_sr[14:8] < 7'(NREGS)) periph[rx_sr[10:8]] = rx_sr[7:0];
                    rx_count++;
                    last_frame = rx_sr;
                end
                high_len = 0;
            end
            high_len++;
        end
        prev_ncs  = nCS;
        prev_sclk = sCLK;
    end

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_cmd(input logic [6:0] a, input logic [7:0] d);
        logic rdy;
        int   n;
        n = 0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_data = d;
        forever begin
            @(negedge clk);
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            if (rdy || n > LIMIT) break;
            n++;
        end
        cmd_valid = 1'b0;
        if (rdy) model_push(a, d);
        else     check("push_accept_timeout", rdy, 1);
    endtask

    task automatic wait_ncs(input logic lvl, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (nCS !== lvl && n < LIMIT);
        check(tag, nCS, lvl);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy !== 1'b0 && n < 4 * LIMIT);
        check(tag, busy, 0);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NREGS; i++) check($sformatf("%s_reg%0d", tag, i), periph[i], exp_regs[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] snap [NREGS];
        logic [7:0] lb_data [NREGS];
        logic       pn;
        int         n, rx_before;

        for (int i = 0; i < NREGS; i++) begin
            exp_regs[i] = '0;
            periph[i]   = '0;
        end

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready_low", cmd_ready, 0);
        to_drive();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ncs", nCS, 1);
        check("rst_sclk", sCLK, 0);
        check("rst_copi", COPI, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_frames_done", frames_done, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);

        // Single write 0x04 <- 0x80 with cycle-exact handshakes
        to_drive();
        cmd_valid = 1'b1; cmd_addr = ADDR_PWM_DUTY; cmd_data = 8'h80;
        @(negedge clk);
        check("single_busy_before", busy, 0);
        check("single_ready", cmd_ready, 1);
        to_drive();
        cmd_valid = 1'b0;
        model_push(ADDR_PWM_DUTY, 8'h80);
        @(negedge clk);
        check("single_busy_after_push", busy, 1);
        check("single_count_1", fifo_count, 1);
        check("single_pop_cycle_ncs", nCS, 1);
        @(negedge clk);
        check("single_ncs_fall", nCS, 0);
        check("single_count_0", fifo_count, 0);
        wait_ncs(1'b1, "single_ncs_rise");
        check("single_frames_at_hold_exit", frames_done, 1);
        check("single_busy_gap_start", busy, 1);
        repeat (GAP_CYCLES - 1) @(negedge clk);
        check("single_busy_gap_end", busy, 1);
        @(negedge clk);
        check("single_busy_idle", busy, 0);
        check("single_frame_value", last_frame, 16'h8480);
        check("single_frames_done", frames_done, 1);

        // Loopback into the peripheral register model, then an unmapped write
        lb_data = '{8'hA5, 8'h5A, 8'hFF, 8'h01, 8'h40};
        to_drive();
        push_cmd(ADDR_EN_OUT_7_0,  lb_data[0]);
        push_cmd(ADDR_EN_OUT_15_8, lb_data[1]);
        push_cmd(ADDR_EN_PWM_7_0,  lb_data[2]);
        push_cmd(ADDR_EN_PWM_15_8, lb_data[3]);
        push_cmd(ADDR_PWM_DUTY,    lb_data[4]);
        push_cmd(7'h07, 8'h3C);
        wait_idle("loop_idle");
        for (int i = 0; i < NREGS; i++) check($sformatf("loop_reg%0d", i), periph[i], lb_data[i]);
        check("loop_frames_done", frames_done, 7);

        // Push coinciding with the IDLE pop while two entries are queued
        to_drive();
        push_cmd(7'($urandom_range(0, 127)), 8'($urandom));
        wait_ncs(1'b0, "simul_first_frame");
        to_drive();
        push_cmd(7'($urandom_range(0, 127)), 8'($urandom));
        push_cmd(7'($urandom_range(0, 127)), 8'($urandom));
        wait_ncs(1'b1, "simul_first_end");
        repeat (GAP_CYCLES) @(posedge clk);
        #1;
        cmd_valid = 1'b1; cmd_addr = 7'($urandom_range(0, 127)); cmd_data = 8'($urandom);
        @(negedge clk);
        check("simul_count_before", fifo_count, 2);
        check("simul_pop_cycle_ncs", nCS, 1);
        to_drive();
        cmd_valid = 1'b0;
        model_push(cmd_addr, cmd_data);
        @(negedge clk);
        check("simul_count_after", fifo_count, 2);
        check("simul_ncs_fall", nCS, 0);
        wait_idle("simul_idle");

        // FIFO full while a frame is in flight; back-to-back frame period
        fall_cyc.delete();
        to_drive();
        push_cmd(7'($urandom_range(0, 127)), 8'($urandom));
        wait_ncs(1'b0, "full_first_frame");
        to_drive();
        for (int i = 0; i < FIFO_DEPTH; i++) push_cmd(7'($urandom_range(0, 127)), 8'($urandom));
        @(negedge clk);
        check("full_count", fifo_count, FIFO_DEPTH);
        check("full_ready_low", cmd_ready, 0);
        to_drive();
        cmd_valid = 1'b1; cmd_addr = 7'($urandom_range(0, 127)); cmd_data = 8'($urandom);
        pn = nCS;
        n  = 0;
        forever begin
            @(negedge clk);
            if (cmd_ready === 1'b1 || n > LIMIT) break;
            pn = nCS;
            n++;
        end
        check("full_ready_rise", cmd_ready, 1);
        check("full_ready_prev_pop_cycle", pn, 1);
        check("full_ready_ncs_low", nCS, 0);
        to_drive();
        cmd_valid = 1'b0;
        model_push(cmd_addr, cmd_data);
        wait_idle("full_idle");
        check("full_frame_count", fall_cyc.size(), FIFO_DEPTH + 2);
        for (int i = 1; i < fall_cyc.size(); i++)
            check($sformatf("full_period%0d", i), fall_cyc[i] - fall_cyc[i-1], PERIOD);

        // Reset during bit 7 of a frame with more commands queued
        snap = exp_regs;
        to_drive();
        push_cmd(ADDR_EN_PWM_7_0, ~exp_regs[2]);
        wait_ncs(1'b0, "rstmid_frame");
        to_drive();
        push_cmd(ADDR_EN_PWM_15_8, ~exp_regs[3]);
        push_cmd(ADDR_EN_OUT_7_0, ~exp_regs[0]);
        n = 0;
        while (bits < 9 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("rstmid_bits_seen", bits, 9);
        to_drive();
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid_ready_in_reset", cmd_ready, 0);
        to_drive();
        rst_n = 1'b1;
        exp_q.delete();
        exp_regs = snap;
        rx_before = rx_count;
        @(negedge clk);
        check("rstmid_ncs", nCS, 1);
        check("rstmid_sclk", sCLK, 0);
        check("rstmid_copi", COPI, 0);
        check("rstmid_count", fifo_count, 0);
        check("rstmid_frames_done", frames_done, 0);
        check("rstmid_busy", busy, 0);
        repeat (3 * PERIOD) @(negedge clk);
        check("rstmid_no_frames", rx_count - rx_before, 0);
        check("rstmid_still_idle", busy, 0);
        check_regs("rstmid");

        // 257 random frames: frames_done wraps to 1, none dropped
        rx_before = rx_count;
        to_drive();
        for (int i = 0; i < 257; i++) begin
            push_cmd(7'($urandom_range(0, 127)), 8'($urandom));
            if ($urandom_range(0, 7) == 0)
                repeat ($urandom_range(1, 30)) begin
                    @(posedge clk);
                    #1;
                end
        end
        wait_idle("wrap_idle");
        check("wrap_frames_done", frames_done, 8'h01);
        check("wrap_rx_count", rx_count - rx_before, 257);
        check_regs("wrap");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
